// File: rtl/cla_pkg.sv
// Shared definitions for the byte-serial CLA adder: byte width and FSM encoding.
package cla_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_8bit.sv
// Combinational 8-bit carry-lookahead adder; every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       term;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        // c[i] = cin&p[0..i-1] | OR_j ( g[j] & p[j+1..i-1] )
        for (int i = 1; i <= 8; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-precision adder: feeds one byte per clock (LSB first) through a single
// cla_8bit, chaining the carry through a flop, with valid/ready on both sides.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_sh_q, sum_sh_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic [BYTE_W-1:0]   cla_sum;
    logic                cla_cout;
    logic [W+BYTE_W-1:0] sum_cat;

    cla_8bit u_cla (
        .a    (a_sh_q[BYTE_W-1:0]),
        .b    (b_sh_q[BYTE_W-1:0]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // New byte enters at the top so byte 0 ends up in the low bits after NBYTES shifts.
    assign sum_cat = {cla_sum, sum_sh_q};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> BYTE_W;
                b_sh_d   = b_sh_q >> BYTE_W;
                sum_sh_d = sum_cat[W+BYTE_W-1:BYTE_W];
                carry_d  = cla_cout;
                if (idx_q == IDX_LAST) begin
                    // Result registers hold the previous answer until this one is complete.
                    idx_d   = '0;
                    sum_d   = sum_cat[W+BYTE_W-1:BYTE_W];
                    cout_d  = cla_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Randomized and directed bench for cla_serial_adder (NBYTES=4 and NBYTES=1 instances)
// against an arithmetic reference: {cout,sum} = a + b + cin.
module tb_cla_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [31:0] a, b, sum;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [7:0]  a1, b1, sum1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    cla_serial_adder #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on the 4-byte instance: idle gap, accept, latency check,
    // optional junk in_valid while busy, bp cycles of backpressure, handshake.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                          input int gap, input int bp, input bit junk, input string tag);
        logic [32:0] exp;
        int t;
        int lat;
        exp = {1'b0, oa} + {1'b0, ob} + 33'(oc);
        repeat (gap) @(negedge clk);
        a = oa; b = ob; cin = oc; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk({tag, " accept"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd4);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; a = ~oa; b = ~ob;
            chk({tag, " bp valid"}, 64'(out_valid), 64'd1);
            chk({tag, " bp in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, " bp sum"}, 64'(sum), 64'(exp[31:0]));
            @(negedge clk);
        end
        chk({tag, " sum"}, 64'(sum), 64'(exp[31:0]));
        chk({tag, " cout"}, 64'(cout), 64'(exp[32]));
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " no dup"}, 64'(out_valid), 64'd0);
        chk({tag, " idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op1(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                           input string tag);
        logic [8:0] exp;
        exp = {1'b0, oa} + {1'b0, ob} + 9'(oc);
        @(negedge clk);
        a1 = oa; b1 = ob; cin1 = oc; in_valid1 = 1'b1;
        chk({tag, " accept"}, 64'(in_ready1), 64'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        chk({tag, " busy"}, 64'(busy1), 64'd1);
        @(negedge clk);
        chk({tag, " valid"}, 64'(out_valid1), 64'd1);
        chk({tag, " sum"}, 64'(sum1), 64'(exp[7:0]));
        chk({tag, " cout"}, 64'(cout1), 64'(exp[8]));
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk({tag, " done"}, 64'(out_valid1), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst sum", 64'(sum), 64'd0);
        chk("rst cout", 64'(cout), 64'd0);
        rst_n = 1'b1;

        run_op(32'h0, 32'h0, 1'b0, 1, 0, 1'b0, "zero");
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 0, 0, 1'b0, "wrap");
        run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 0, 0, 1'b0, "carry_a");
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 2, 0, 1'b0, "carry_b");
        run_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 0, 5, 1'b1, "backpressure");

        // Abort a transaction at idx=2 and confirm no result escapes.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst no result", 64'(out_valid), 64'd0);
        end
        run_op(32'd200, 32'd100, 1'b1, 0, 0, 1'b0, "after_rst");

        for (int n = 0; n < 50; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (n % 10 == 0) ra = 32'hFFFF_FFFF;
            if (n % 10 == 5) rb = ~ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b1, $sformatf("rand%0d", n));
        end

        run_op1(8'hC8, 8'h64, 1'b1, "n1_dir");
        run_op1(8'hFF, 8'h00, 1'b1, "n1_wrap");
        for (int n = 0; n < 8; n++)
            run_op1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    $sformatf("n1_rand%0d", n));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
